// File: rtl/genome_rank_sorter.sv
// Bubble-sorts networks by fitness and mirrors every swap into external genome RAM,
// so genome block k holds the rank-k network's genome once the sort completes.
module genome_rank_sorter #(
  parameter int unsigned NETWORKS   = 16,
  parameter int unsigned FIT_W      = 16,
  parameter int unsigned GENE_WORDS = 11,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned BASE_ADDR  = 0,
  localparam int unsigned NW        = $clog2(NETWORKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [NW-1:0]     load_idx,
  input  logic [FIT_W-1:0]  load_fitness,
  input  logic              start,
  input  logic              descending,
  output logic              busy,
  output logic              done,
  output logic [15:0]       swap_count,
  input  logic [NW-1:0]     rank_idx,
  output logic [FIT_W-1:0]  rank_fitness,
  output logic [NW-1:0]     rank_net,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  localparam int unsigned GW = (GENE_WORDS > 1) ? $clog2(GENE_WORDS) : 1;
  localparam int unsigned CW = 16;
  localparam logic [NW-1:0] LAST_PASS = NW'(NETWORKS - 2);
  localparam logic [GW-1:0] LAST_WORD = GW'(GENE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, CMP, RD_A, RD_B, WR_A, WR_B, DONE} state_t;
  state_t state, stateNext;

  logic [FIT_W-1:0]  fitTab [NETWORKS];
  logic [NW-1:0]     netTab [NETWORKS];
  logic [DATA_W-1:0] bufA [GENE_WORDS];
  logic [DATA_W-1:0] bufB [GENE_WORDS];

  logic [NW-1:0]     idx, idxNext, pass, passNext, idxP1, lastIdx;
  logic [GW-1:0]     word, wordNext;
  logic              swapped, swappedNext, descReg, descNext;
  logic [CW-1:0]     swapNext;
  logic              busyNext, doneNext, reqNext, weNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;
  logic              doSwap, doLoad, capA, capB, advance, needSwap;
  logic [FIT_W-1:0]  fitA, fitB;

  // Word address of a genome word; wraps modulo 2^ADDR_W by truncation
  function automatic logic [ADDR_W-1:0] blockAddr(input logic [NW-1:0] blk, input logic [GW-1:0] w);
    logic [63:0] full;
    full = 64'(BASE_ADDR) + 64'(blk) * 64'(GENE_WORDS) + 64'(w);
    return ADDR_W'(full);
  endfunction

  assign idxP1        = idx + NW'(1);
  assign lastIdx      = LAST_PASS - pass;
  assign fitA         = fitTab[idx];
  assign fitB         = fitTab[idxP1];
  assign needSwap     = descReg ? (fitA < fitB) : (fitA > fitB);
  assign rank_fitness = fitTab[rank_idx];
  assign rank_net     = netTab[rank_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    idxNext     = idx;
    passNext    = pass;
    swappedNext = swapped;
    descNext    = descReg;
    wordNext    = word;
    swapNext    = swap_count;
    reqNext     = ram_req;
    weNext      = ram_we;
    addrNext    = ram_addr;
    wdataNext   = ram_wdata;
    doSwap      = 1'b0;
    doLoad      = 1'b0;
    capA        = 1'b0;
    capB        = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        doLoad    = load_en;
        if (start) begin
          stateNext   = CMP;
          idxNext     = '0;
          passNext    = '0;
          swappedNext = 1'b0;
          swapNext    = '0;
          descNext    = descending;
        end
      end
      CMP: begin
        if (needSwap) begin
          doSwap      = 1'b1;
          swappedNext = 1'b1;
          if (swap_count != '1) swapNext = swap_count + CW'(1);
          wordNext    = '0;
          reqNext     = 1'b1;
          weNext      = 1'b0;
          addrNext    = blockAddr(idx, '0);
          stateNext   = RD_A;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        // Genome move: one request per word, request dropped for a cycle after each ack
        if (ram_req && ram_ack) begin
          reqNext = 1'b0;
          capA    = (state == RD_A);
          capB    = (state == RD_B);
          if (word == LAST_WORD) begin
            wordNext = '0;
            case (state)
              RD_A:    stateNext = RD_B;
              RD_B:    stateNext = WR_A;
              WR_A:    stateNext = WR_B;
              default: advance   = 1'b1;
            endcase
          end else begin
            wordNext = word + GW'(1);
          end
        end else if (!ram_req) begin
          reqNext   = 1'b1;
          weNext    = (state == WR_A) || (state == WR_B);
          addrNext  = blockAddr(((state == RD_A) || (state == WR_A)) ? idx : idxP1, word);
          wdataNext = (state == WR_A) ? bufB[word] : bufA[word];
        end
      end
    endcase
    if (advance) begin
      if (idx == lastIdx) begin
        if (!swapped || pass == LAST_PASS) begin
          stateNext = DONE;
        end else begin
          passNext    = pass + NW'(1);
          idxNext     = '0;
          swappedNext = 1'b0;
          stateNext   = CMP;
        end
      end else begin
        idxNext   = idxP1;
        stateNext = CMP;
      end
    end
    busyNext = (stateNext != IDLE) && (stateNext != DONE);
    doneNext = (stateNext == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      pass       <= '0;
      word       <= '0;
      swapped    <= 1'b0;
      descReg    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      for (int k = 0; k < NETWORKS; k++) begin
        fitTab[k] <= '0;
        netTab[k] <= NW'(k);
      end
    end else begin
      idx        <= idxNext;
      pass       <= passNext;
      word       <= wordNext;
      swapped    <= swappedNext;
      descReg    <= descNext;
      busy       <= busyNext;
      done       <= doneNext;
      swap_count <= swapNext;
      ram_req    <= reqNext;
      ram_we     <= weNext;
      ram_addr   <= addrNext;
      ram_wdata  <= wdataNext;
      if (doLoad) begin
        fitTab[load_idx] <= load_fitness;
        netTab[load_idx] <= load_idx;
      end
      if (doSwap) begin
        fitTab[idx]   <= fitB;
        fitTab[idxP1] <= fitA;
        netTab[idx]   <= netTab[idxP1];
        netTab[idxP1] <= netTab[idx];
      end
    end
  end

  // Genome staging buffers carry no reset; they are always filled before being written back
  always_ff @(posedge clk) begin
    if (capA) bufA[word] <= ram_rdata;
    if (capB) bufB[word] <= ram_rdata;
  end

endmodule

// File: tb/tb_genome_rank_sorter.sv
// Directed bench for genome_rank_sorter: 4 networks, 3-word genomes at base address 5,
// with a behavioural RAM that adds random ack latency and watches the handshake.
module tb_genome_rank_sorter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [1:0]  load_idx = '0;
  logic [15:0] load_fitness = '0;
  logic        start = 1'b0;
  logic        descending = 1'b0;
  logic        busy, done;
  logic [15:0] swap_count;
  logic [1:0]  rank_idx = '0;
  logic [15:0] rank_fitness;
  logic [1:0]  rank_net;
  logic        ram_req, ram_we;
  logic [22:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;

  int total = 0;
  int bad = 0;
  int protoErr = 0;
  int reqSeen = 0;
  int maxDelay = 0;
  int expFit [4];
  int expId [4];
  logic [15:0] mem [32];

  genome_rank_sorter #(
    .NETWORKS(4), .FIT_W(16), .GENE_WORDS(3), .DATA_W(16), .ADDR_W(23), .BASE_ADDR(5)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx), .load_fitness(load_fitness),
    .start(start), .descending(descending), .busy(busy), .done(done), .swap_count(swap_count),
    .rank_idx(rank_idx), .rank_fitness(rank_fitness), .rank_net(rank_net),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  // RAM model: random ack latency, flags unstable requests, missing gaps and stray addresses
  logic        holding = 1'b0;
  logic [22:0] hAddr;
  logic        hWe;
  logic [15:0] hData;
  int          delay = 0;
  always @(negedge clk) begin
    if (rst) begin
      ram_ack = 1'b0;
      holding = 1'b0;
    end else if (ram_ack) begin
      ram_ack = 1'b0;
      holding = 1'b0;
      if (ram_req !== 1'b0) protoErr++;
    end else if (ram_req === 1'b1) begin
      reqSeen++;
      if (!holding) begin
        holding = 1'b1;
        hAddr = ram_addr;
        hWe = ram_we;
        hData = ram_wdata;
        delay = $urandom_range(maxDelay, 0);
        if (ram_addr < 23'd5 || ram_addr > 23'd16) protoErr++;
      end else if (ram_addr !== hAddr || ram_we !== hWe || ram_wdata !== hData) begin
        protoErr++;
      end
      if (delay == 0) begin
        ram_ack = 1'b1;
        if (ram_we) mem[ram_addr[4:0]] = ram_wdata;
        else ram_rdata = mem[ram_addr[4:0]];
      end else begin
        delay--;
      end
    end
  end

  function automatic logic [15:0] pat(input int k, input int w);
    return 16'(16'hA000 + k * 16 + w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic initRam();
    for (int a = 0; a < 32; a++) mem[a] = 16'h0;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 3; w++) mem[5 + k * 3 + w] = pat(k, w);
  endtask

  task automatic loadAll(input int f0, input int f1, input int f2, input int f3);
    int f [4];
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_en = 1'b1;
      load_idx = 2'(k);
      load_fitness = 16'(f[k]);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic doStart(input logic desc);
    @(negedge clk);
    start = 1'b1;
    descending = desc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 1;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < 4000), 32'd1);
  endtask

  task automatic checkTable(input string tag);
    for (int k = 0; k < 4; k++) begin
      rank_idx = 2'(k);
      #1;
      check($sformatf("%s_fit%0d", tag, k), 32'(rank_fitness), 32'(expFit[k]));
      check($sformatf("%s_id%0d", tag, k), 32'(rank_net), 32'(expId[k]));
    end
  endtask

  task automatic checkRam(input string tag);
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 3; w++)
        check($sformatf("%s_b%0d_w%0d", tag, k, w), 32'(mem[5 + k * 3 + w]), 32'(pat(expId[k], w)));
  endtask

  task automatic setExp(input int f0, input int f1, input int f2, input int f3,
                        input int i0, input int i1, input int i2, input int i3);
    expFit[0] = f0; expFit[1] = f1; expFit[2] = f2; expFit[3] = f3;
    expId[0] = i0; expId[1] = i1; expId[2] = i2; expId[3] = i3;
  endtask

  initial begin
    int n;
    int g;
    initRam();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_swaps", 32'(swap_count), 32'd0);
    check("rst_req", 32'(ram_req), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    setExp(0, 0, 0, 0, 0, 1, 2, 3);
    checkTable("rst");
    @(negedge clk);
    rst = 1'b0;

    // Descending {5,9,1,7} -> {9,7,5,1}, ids {1,3,0,2}, three swaps
    loadAll(5, 9, 1, 7);
    doStart(1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    waitDone(n);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_swaps", 32'(swap_count), 32'd3);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    setExp(9, 7, 5, 1, 1, 3, 0, 2);
    checkTable("t1");
    checkRam("t1");
    check("t1_proto", 32'(protoErr), 32'd0);

    // Already sorted: 3 compares, done on the 4th edge after start (5 cycles incl. start), no RAM
    initRam();
    reqSeen = 0;
    loadAll(9, 7, 5, 1);
    doStart(1'b1);
    waitDone(n);
    check("t2_latency", 32'(n), 32'd4);
    check("t2_swaps", 32'(swap_count), 32'd0);
    check("t2_no_req", 32'(reqSeen), 32'd0);
    setExp(9, 7, 5, 1, 0, 1, 2, 3);
    checkTable("t2");
    checkRam("t2");

    // Ascending with ties stays stable: {3,3,2,4} -> {2,3,3,4}, ids {2,0,1,3}
    initRam();
    loadAll(3, 3, 2, 4);
    doStart(1'b0);
    waitDone(n);
    check("t3_swaps", 32'(swap_count), 32'd2);
    setExp(2, 3, 3, 4, 2, 0, 1, 3);
    checkTable("t3");
    checkRam("t3");

    // Slow RAM plus load/start while busy (both ignored): same result as the first sort
    initRam();
    maxDelay = 7;
    loadAll(5, 9, 1, 7);
    doStart(1'b1);
    repeat (3) @(negedge clk);
    load_en = 1'b1;
    load_idx = 2'd0;
    load_fitness = 16'd100;
    start = 1'b1;
    descending = 1'b0;
    @(negedge clk);
    load_en = 1'b0;
    start = 1'b0;
    check("t4_still_busy", 32'(busy), 32'd1);
    waitDone(n);
    check("t4_swaps", 32'(swap_count), 32'd3);
    setExp(9, 7, 5, 1, 1, 3, 0, 2);
    checkTable("t4");
    checkRam("t4");
    check("t4_proto", 32'(protoErr), 32'd0);

    // Reset while the first genome write is outstanding
    initRam();
    maxDelay = 3;
    loadAll(5, 9, 1, 7);
    doStart(1'b1);
    g = 0;
    while (!(ram_req === 1'b1 && ram_we === 1'b1) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("t5_reached_write", 32'(g < 2000), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_req", 32'(ram_req), 32'd0);
    check("t5_we", 32'(ram_we), 32'd0);
    check("t5_addr", 32'(ram_addr), 32'd0);
    check("t5_wdata", 32'(ram_wdata), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_swaps", 32'(swap_count), 32'd0);
    setExp(0, 0, 0, 0, 0, 1, 2, 3);
    checkTable("t5");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_idle_req", 32'(ram_req), 32'd0);
    check("t5_proto", 32'(protoErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
